manycore_net_endpoint: RTL and testbench
========================================

# manycore_net_endpoint

Network endpoint for a manycore tile. It buffers incoming mesh packets in a small FIFO and decodes the head packet into remote-store, freeze and unfreeze commands. It holds the tile freeze state and encodes the core's remote store requests into outgoing mesh packets. It sits between the mesh router port and the tile's core and memory crossbar.

## Interface
Parameters:
- x_cord_width_p, 5: x coordinate width (x_w).
- y_cord_width_p, 5: y coordinate width (y_w).
- data_width_p, 32: data width (must be a multiple of 8); mask_w = data_width_p/8.
- addr_width_p, 32: word-address width of a packet; also the width of the core byte address.
- fifo_els_p, 4: input FIFO depth (≥2).
- Derived: packet width P = addr_width_p+2+mask_w+data_width_p+y_w+x_w (80 at defaults). Local-offset width L = addr_width_p-3-x_w-y_w.
- Packet layout, MSB→LSB: addr, op[1:0], mask, data, y_cord, x_cord.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- in_v_i / in_data_i / in_ready_o  in/in/out  1/P/1  network input, valid-ready.
- rs_v_o  out  1  head is a remote store.
- rs_addr_o / rs_data_o / rs_mask_o  out  addr_width_p/data_width_p/mask_w  head packet fields.
- rs_yumi_i  in  1  consumer accepts the store; dequeues the head.
- unknown_o  out  1  head has an unknown op (pulse, dropped).
- freeze_o  out  1  tile freeze state.
- req_v_i / req_addr_i / req_data_i / req_we_i / req_mask_i  in  1/addr_width_p/data_width_p/1/mask_w  core memory request (byte address).
- req_yumi_o  out  1  remote store taken by the network.
- out_v_o / out_data_o / out_ready_i  out/out/in  1/P/1  network output.

## Operation
- FIFO: enqueue when in_v_i & in_ready_o; in_ready_o = not full. No write-through when full, even if dequeueing. Head is read combinationally; head valid = not empty. Dequeue fires on the internal yumi. Pointers wrap modulo fifo_els_p.
- Decode, gated by head valid:
  - op 2'b01 → remote store.
  - op 2'b10 with mask[0]=1 → freeze; with mask[0]=0 → unfreeze.
  - op 2'b00 and 2'b11 → unknown.
- rs_addr_o/rs_data_o/rs_mask_o always reflect the head fields.
- Internal yumi = (rs_v_o & rs_yumi_i) | freeze | unfreeze | unknown. Config and unknown packets are consumed automatically in one cycle. rs_yumi_i is ignored when rs_v_o=0.
- freeze_o register: set to 1 on a freeze packet, cleared to 0 on an unfreeze packet, held otherwise.
- Encode: remote = req_v_i & req_addr_i[addr_width_p-1] & req_we_i. Outgoing fields:
  - op = 2'b01, mask = req_mask_i, data = req_data_i.
  - y_cord = req_addr_i[2+L+x_w +: y_w].
  - x_cord = req_addr_i[2+L +: x_w].
  - addr = zero-extended req_addr_i[2 +: L].
- out_v_o = remote; out_data_o purely combinational; req_yumi_o = out_v_o & out_ready_i.
- Local requests and remote loads: out_v_o=0, req_yumi_o=0. The block does not handle them.

## Timing
- Reset (asynchronous): FIFO empty, freeze_o=1, in_ready_o=1, rs_v_o=0, unknown_o=0. out_v_o follows req inputs combinationally.
- A packet enqueued at edge t is decoded in cycle t+1 (one-cycle latency, no bypass).
- freeze_o changes at the edge that dequeues the config packet.
- Back-to-back dequeue/enqueue sustains one packet per cycle when not full.
- Simultaneous enqueue and dequeue when not full or empty: count unchanged.
- Reset mid-operation discards all queued packets.
- The encoder path has zero latency and is stateless.

## Test plan
- Reset with in_v_i=0 → freeze_o=1, in_ready_o=1, rs_v_o=0.
- Enqueue unfreeze (op=2, mask=0) → next cycle auto-dequeued, freeze_o=0 after the following edge. Then freeze (mask=4'b0001) → freeze_o=1.
- Enqueue 4 stores (addr 0..3, data 0xA0..0xA3) with rs_yumi_i=0 → in_ready_o=0 after the 4th. 5th in_v_i is not accepted. Raise rs_yumi_i → data 0xA0..0xA3 in order, in_ready_o=1 after the first dequeue.
- Store addr=0x10, data=0xDEADBEEF, mask=4'hF → rs_v_o=1, rs_addr_o=0x10, rs_data_o=0xDEADBEEF. Held until rs_yumi_i.
- Enqueue op=2'b11 → unknown_o=1 for one cycle, dropped, freeze_o unchanged.
- req_v_i=1, we=1, addr=0x8C400010, data=0x12345678, mask=4'h3, out_ready_i=1 → out_v_o=1, y=3, x=2, addr=4, op=1, mask=3, req_yumi_o=1. With addr=0x0C400010 or we=0 → out_v_o=0.

Source files
------------

// File: rtl/manycore_net_endpoint.sv
// Manycore tile network endpoint: input FIFO with remote-store/config decode,
// tile freeze register, and a stateless remote-store packet encoder.
module manycore_net_endpoint #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int fifo_els_p     = 4,
  localparam int mask_w = data_width_p / 8,
  localparam int pkt_w  = addr_width_p + 2 + mask_w + data_width_p
                        + y_cord_width_p + x_cord_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    in_v_i,
  input  logic [pkt_w-1:0]        in_data_i,
  output logic                    in_ready_o,

  output logic                    rs_v_o,
  output logic [addr_width_p-1:0] rs_addr_o,
  output logic [data_width_p-1:0] rs_data_o,
  output logic [mask_w-1:0]       rs_mask_o,
  input  logic                    rs_yumi_i,
  output logic                    unknown_o,
  output logic                    freeze_o,

  input  logic                    req_v_i,
  input  logic [addr_width_p-1:0] req_addr_i,
  input  logic [data_width_p-1:0] req_data_i,
  input  logic                    req_we_i,
  input  logic [mask_w-1:0]       req_mask_i,
  output logic                    req_yumi_o,

  output logic                    out_v_o,
  output logic [pkt_w-1:0]        out_data_o,
  input  logic                    out_ready_i
);

  localparam int xw = x_cord_width_p;
  localparam int yw = y_cord_width_p;
  localparam int lw = addr_width_p - 3 - xw - yw;
  localparam int pw = (fifo_els_p > 2) ? $clog2(fifo_els_p) : 1;
  localparam int cw = $clog2(fifo_els_p + 1);

  logic [pkt_w-1:0] mem [fifo_els_p];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [cw-1:0]    count;
  logic             enq;
  logic             deq;
  logic             head_v;
  logic [pkt_w-1:0] head;
  logic [1:0]       op;
  logic             freeze_cmd;
  logic             unfreeze_cmd;

  function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
    return (p == pw'(fifo_els_p - 1)) ? '0 : p + pw'(1);
  endfunction

  assign in_ready_o = (count != cw'(fifo_els_p));
  assign head_v     = (count != '0);
  assign enq        = in_v_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= nxt(wr_ptr);
      if (deq) rd_ptr <= nxt(rd_ptr);
      unique case ({enq, deq})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign op        = head[pkt_w-addr_width_p-1 -: 2];
  assign rs_addr_o = head[pkt_w-1 -: addr_width_p];
  assign rs_mask_o = head[pkt_w-addr_width_p-3 -: mask_w];
  assign rs_data_o = head[xw+yw +: data_width_p];

  assign rs_v_o       = head_v & (op == 2'b01);
  assign freeze_cmd   = head_v & (op == 2'b10) & rs_mask_o[0];
  assign unfreeze_cmd = head_v & (op == 2'b10) & ~rs_mask_o[0];
  assign unknown_o    = head_v & ((op == 2'b00) | (op == 2'b11));

  // config and unknown packets never wait for the consumer
  assign deq = (rs_v_o & rs_yumi_i) | freeze_cmd | unfreeze_cmd | unknown_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)           freeze_o <= 1'b1;
    else if (freeze_cmd)   freeze_o <= 1'b1;
    else if (unfreeze_cmd) freeze_o <= 1'b0;
  end

  // byte address: [msb]=remote, then y, x, word offset, byte-in-word
  assign out_v_o    = req_v_i & req_addr_i[addr_width_p-1] & req_we_i;
  assign req_yumi_o = out_v_o & out_ready_i;
  assign out_data_o = {
    {(addr_width_p-lw){1'b0}}, req_addr_i[2 +: lw],
    2'b01,
    req_mask_i,
    req_data_i,
    req_addr_i[2+lw+xw +: yw],
    req_addr_i[2+lw +: xw]
  };

  logic unused_byte_off;
  assign unused_byte_off = ^req_addr_i[1:0];

endmodule

// File: tb/tb_manycore_net_endpoint.sv
// Directed scoreboard bench for manycore_net_endpoint.
// Expected store packets and encoder packets are queued at drive time.
module tb_manycore_net_endpoint;

  localparam int P = 80;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          in_v_i;
  logic [P-1:0]  in_data_i;
  logic          in_ready_o;
  logic          rs_v_o;
  logic [31:0]   rs_addr_o;
  logic [31:0]   rs_data_o;
  logic [3:0]    rs_mask_o;
  logic          rs_yumi_i;
  logic          unknown_o;
  logic          freeze_o;
  logic          req_v_i;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_data_i;
  logic          req_we_i;
  logic [3:0]    req_mask_i;
  logic          req_yumi_o;
  logic          out_v_o;
  logic [P-1:0]  out_data_o;
  logic          out_ready_i;

  int n_cmp = 0;
  int n_bad = 0;
  int mcnt  = 0;
  logic [P-1:0] sb_q [$];
  logic [P-1:0] out_q [$];

  manycore_net_endpoint dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_v_i(in_v_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .rs_v_o(rs_v_o), .rs_addr_o(rs_addr_o), .rs_data_o(rs_data_o),
    .rs_mask_o(rs_mask_o), .rs_yumi_i(rs_yumi_i),
    .unknown_o(unknown_o), .freeze_o(freeze_o),
    .req_v_i(req_v_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_we_i(req_we_i), .req_mask_i(req_mask_i), .req_yumi_o(req_yumi_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [P-1:0] mk(
    input logic [31:0] a, input logic [1:0] op, input logic [3:0] m,
    input logic [31:0] d, input logic [4:0] y, input logic [4:0] x);
    return {a, op, m, d, y, x};
  endfunction

  task automatic chk(input string tag, input logic [P-1:0] obs,
                     input logic [P-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt_cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // one cycle of store traffic against the FIFO model and scoreboard
  task automatic step();
    bit enq;
    bit deq;
    logic [P-1:0] e;
    #1;
    chk("in_ready", in_ready_o, mcnt < 4);
    chk("rs_v", rs_v_o, sb_q.size() > 0);
    enq = in_v_i && (mcnt < 4);
    deq = rs_yumi_i && (sb_q.size() > 0);
    if (deq) begin
      e = sb_q.pop_front();
      chk("rs_addr", rs_addr_o, e[79:48]);
      chk("rs_mask", rs_mask_o, e[45:42]);
      chk("rs_data", rs_data_o, e[41:10]);
    end
    if (enq) sb_q.push_back(in_data_i);
    mcnt = mcnt + int'(enq) - int'(deq);
    nxt_cyc();
  endtask

  task automatic cfg(input logic [1:0] op, input logic [3:0] m,
                     input logic fz_before, input logic fz_after,
                     input logic unk);
    in_v_i    = 1'b1;
    in_data_i = mk(32'h77, op, m, 32'h0, 5'd0, 5'd0);
    #1 chk("cfg_ready", in_ready_o, 1'b1);
    nxt_cyc();
    in_v_i = 1'b0;
    #1;
    chk("cfg_unknown", unknown_o, unk);
    chk("cfg_rs_v", rs_v_o, 1'b0);
    chk("cfg_freeze_pre", freeze_o, fz_before);
    nxt_cyc();
    #1;
    chk("cfg_freeze_post", freeze_o, fz_after);
    chk("cfg_unknown_post", unknown_o, 1'b0);
    nxt_cyc();
  endtask

  task automatic enc(input logic [31:0] a, input logic we,
                     input logic rdy, input logic [P-1:0] exp_pkt,
                     input logic exp_v);
    logic [P-1:0] e;
    req_v_i     = 1'b1;
    req_addr_i  = a;
    req_data_i  = 32'h12345678;
    req_we_i    = we;
    req_mask_i  = 4'h3;
    out_ready_i = rdy;
    if (exp_v) out_q.push_back(exp_pkt);
    #1;
    chk("out_v", out_v_o, exp_v);
    chk("req_yumi", req_yumi_o, exp_v & rdy);
    if (out_v_o && out_q.size() > 0) begin
      e = out_q.pop_front();
      chk("out_data", out_data_o, e);
    end
    nxt_cyc();
  endtask

  initial begin
    reset_i     = 1'b1;
    in_v_i      = 1'b0;
    in_data_i   = '0;
    rs_yumi_i   = 1'b0;
    req_v_i     = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_we_i    = 1'b0;
    req_mask_i  = '0;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_freeze", freeze_o, 1'b1);
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_rs_v", rs_v_o, 1'b0);
    chk("rst_unknown", unknown_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    nxt_cyc();

    cfg(2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
    cfg(2'b10, 4'b0001, 1'b0, 1'b1, 1'b0);

    // fill to full with the consumer stalled, then one rejected offer
    for (int i = 0; i < 4; i++) begin
      in_v_i    = 1'b1;
      in_data_i = mk(32'(i), 2'b01, 4'hF, 32'hA0 + 32'(i), 5'd1, 5'd2);
      step();
    end
    in_data_i = mk(32'h4, 2'b01, 4'hF, 32'hA4, 5'd1, 5'd2);
    step();
    in_v_i    = 1'b0;
    rs_yumi_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rs_yumi_i = 1'b0;
    chk("fill_drained", sb_q.size(), 0);

    in_v_i    = 1'b1;
    in_data_i = mk(32'h10, 2'b01, 4'hF, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    in_v_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rs_yumi_i = 1'b1;
    step();
    rs_yumi_i = 1'b0;
    step();

    // streaming: enqueue and dequeue in the same cycle
    rs_yumi_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_v_i    = 1'b1;
      in_data_i = mk(32'h100 + 32'(i), 2'b01, 4'(i + 1), 32'hB0 + 32'(i),
                     5'd3, 5'd4);
      step();
    end
    in_v_i = 1'b0;
    step();
    step();
    rs_yumi_i = 1'b0;
    chk("stream_drained", sb_q.size(), 0);

    cfg(2'b11, 4'b0001, 1'b1, 1'b1, 1'b1);
    cfg(2'b00, 4'b0000, 1'b1, 1'b1, 1'b1);

    enc(32'h8C400010, 1'b1, 1'b1,
        mk(32'd4, 2'b01, 4'h3, 32'h12345678, 5'd3, 5'd2), 1'b1);
    enc(32'h8C400010, 1'b1, 1'b0,
        mk(32'd4, 2'b01, 4'h3, 32'h12345678, 5'd3, 5'd2), 1'b1);
    enc(32'hFBE0001C, 1'b1, 1'b1,
        mk(32'd7, 2'b01, 4'h3, 32'h12345678, 5'd30, 5'd31), 1'b1);
    enc(32'h0C400010, 1'b1, 1'b1, '0, 1'b0);
    enc(32'h8C400010, 1'b0, 1'b1, '0, 1'b0);
    req_v_i = 1'b0;
    #1 chk("enc_idle", out_v_o, 1'b0);
    chk("enc_q_empty", out_q.size(), 0);
    nxt_cyc();

    // reset with packets queued and the tile unfrozen
    cfg(2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_v_i    = 1'b1;
      in_data_i = mk(32'h200, 2'b01, 4'h1, 32'hC0 + 32'(i), 5'd0, 5'd1);
      step();
    end
    in_v_i  = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_rs_v", rs_v_o, 1'b0);
    chk("mid_rst_ready", in_ready_o, 1'b1);
    chk("mid_rst_freeze", freeze_o, 1'b1);
    nxt_cyc();
    reset_i = 1'b0;
    sb_q.delete();
    mcnt = 0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
